// File: rtl/trap_ctrl.sv
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Trap/interrupt controller placed in front of the CSR file.
//            Arbitrates synchronous exceptions, MRET and the three machine
//            interrupts (external, software, timer). It produces the
//            IntEntry/IntExit strobes and the mcause/mepc/mtval values for
//            the CSR file. It also issues a PC redirect to fetch through a
//            valid/ack handshake.
// Revision : 1.0 - initial release
//
// Ports
//   Clk, ResetN                  clock (rising edge), async active-low reset
//   ExtIrq                       async level external irq (synchronized here)
//   SoftIrq, TimerIrq            synchronous level interrupts
//   ExcValid/ExcCause/ExcPC/ExcMtval   exception request (held until ExcAck)
//   MretReq                      MRET request (held until MretAck)
//   InstBoundary, CurrPC         interrupt window and the PC saved as mepc
//   CsrStatus/CsrIe/CsrTvec/CsrEpc     current CSR state
//   IntEntry/IntExit             one-cycle strobes to the CSR file
//   IntCause/IntPC/IntMtval      trap values, valid while IntEntry=1
//   ExcAck, MretAck              one-cycle acceptance pulses
//   RedirectValid/RedirectPC/RedirectAck  fetch redirect handshake
//   Busy                         high in every state except IDLE
// ============================================================================
`default_nettype none

module trap_ctrl #(
  parameter int SYNC_STAGES = 2,     // legal range 2..4
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ExtIrq,
  input  logic        SoftIrq,
  input  logic        TimerIrq,
  input  logic        ExcValid,
  input  logic [3:0]  ExcCause,
  input  logic [31:0] ExcPC,
  input  logic [31:0] ExcMtval,
  input  logic        MretReq,
  input  logic        InstBoundary,
  input  logic [31:0] CurrPC,
  input  logic [31:0] CsrStatus,
  input  logic [31:0] CsrIe,
  input  logic [31:0] CsrTvec,
  input  logic [31:0] CsrEpc,
  output logic        IntEntry,
  output logic        IntExit,
  output logic [31:0] IntCause,
  output logic [31:0] IntPC,
  output logic [31:0] IntMtval,
  output logic        ExcAck,
  output logic        MretAck,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  input  logic        RedirectAck,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    EXIT     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;

  state_t state;

  // External interrupt synchronizer; the MSB is the synchronized level.
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic                   ext_sync;

  logic        mei_pend;
  logic        msi_pend;
  logic        mti_pend;
  logic        irq_eligible;
  logic [3:0]  irq_code;

  // Kind and code of the trap that was latched in IDLE; used in ENTRY to
  // choose between the direct and the vectored target.
  logic        trap_is_irq;
  logic [3:0]  trap_code;

  logic [31:0] tvec_base;
  logic [31:0] entry_target;
  logic [31:0] exit_target;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ext_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ExtIrq};
    end
  end

  assign ext_sync = ext_sync_q[SYNC_STAGES-1];

  always_comb begin
    mei_pend     = ext_sync & CsrIe[11];
    msi_pend     = SoftIrq  & CsrIe[3];
    mti_pend     = TimerIrq & CsrIe[7];
    irq_eligible = CsrStatus[3] & InstBoundary & (mei_pend | msi_pend | mti_pend);

    // Fixed interrupt priority: external > software > timer.
    if (mei_pend) begin
      irq_code = CODE_MEI;
    end else if (msi_pend) begin
      irq_code = CODE_MSI;
    end else begin
      irq_code = CODE_MTI;
    end
  end

  always_comb begin
    tvec_base = {CsrTvec[31:2], 2'b00};
    // Only interrupts are vectored; exceptions always use the base address.
    if (VECTORED_EN && (CsrTvec[1:0] == 2'b01) && trap_is_irq) begin
      entry_target = tvec_base + {26'd0, trap_code, 2'b00};
    end else begin
      entry_target = tvec_base;
    end
    exit_target = {CsrEpc[31:1], 1'b0};
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state         <= IDLE;
      IntEntry      <= 1'b0;
      IntExit       <= 1'b0;
      IntCause      <= '0;
      IntPC         <= '0;
      IntMtval      <= '0;
      ExcAck        <= 1'b0;
      MretAck       <= 1'b0;
      RedirectValid <= 1'b0;
      RedirectPC    <= '0;
      Busy          <= 1'b0;
      trap_is_irq   <= 1'b0;
      trap_code     <= '0;
    end else begin
      // The strobes default low so each one lasts exactly one cycle.
      IntEntry <= 1'b0;
      IntExit  <= 1'b0;
      ExcAck   <= 1'b0;
      MretAck  <= 1'b0;

      case (state)
        IDLE: begin
          if (ExcValid) begin
            state       <= ENTRY;
            Busy        <= 1'b1;
            IntEntry    <= 1'b1;
            ExcAck      <= 1'b1;
            IntCause    <= {28'd0, ExcCause};
            IntPC       <= ExcPC;
            IntMtval    <= ExcMtval;
            trap_is_irq <= 1'b0;
            trap_code   <= ExcCause;
          end else if (MretReq) begin
            state   <= EXIT;
            Busy    <= 1'b1;
            IntExit <= 1'b1;
            MretAck <= 1'b1;
          end else if (irq_eligible) begin
            // The cause is captured here. A later drop of the request
            // does not cancel the trap.
            state       <= ENTRY;
            Busy        <= 1'b1;
            IntEntry    <= 1'b1;
            IntCause    <= {1'b1, 27'd0, irq_code};
            IntPC       <= CurrPC;
            IntMtval    <= '0;
            trap_is_irq <= 1'b1;
            trap_code   <= irq_code;
          end
        end

        ENTRY: begin
          state         <= REDIRECT;
          RedirectValid <= 1'b1;
          RedirectPC    <= entry_target;
        end

        EXIT: begin
          state         <= REDIRECT;
          RedirectValid <= 1'b1;
          RedirectPC    <= exit_target;
        end

        REDIRECT: begin
          if (RedirectAck) begin
            state         <= IDLE;
            RedirectValid <= 1'b0;
            Busy          <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // CSR bits that this block does not look at.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{CsrStatus[31:4], CsrStatus[2:0],
                             CsrIe[31:12], CsrIe[10:8], CsrIe[6:4], CsrIe[2:0],
                             CsrEpc[0]};

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed self-checking bench for trap_ctrl. Inputs are driven
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

  localparam int SYNC_STAGES = 2;

  logic        Clk;
  logic        ResetN;
  logic        ExtIrq, SoftIrq, TimerIrq;
  logic        ExcValid;
  logic [3:0]  ExcCause;
  logic [31:0] ExcPC, ExcMtval;
  logic        MretReq, InstBoundary;
  logic [31:0] CurrPC, CsrStatus, CsrIe, CsrTvec, CsrEpc;
  logic        IntEntry, IntExit;
  logic [31:0] IntCause, IntPC, IntMtval;
  logic        ExcAck, MretAck;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        RedirectAck;
  logic        Busy;

  int checks;
  int errors;
  int strobes;

  trap_ctrl #(.SYNC_STAGES(SYNC_STAGES), .VECTORED_EN(1'b1)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ExtIrq(ExtIrq), .SoftIrq(SoftIrq), .TimerIrq(TimerIrq),
    .ExcValid(ExcValid), .ExcCause(ExcCause), .ExcPC(ExcPC), .ExcMtval(ExcMtval),
    .MretReq(MretReq), .InstBoundary(InstBoundary), .CurrPC(CurrPC),
    .CsrStatus(CsrStatus), .CsrIe(CsrIe), .CsrTvec(CsrTvec), .CsrEpc(CsrEpc),
    .IntEntry(IntEntry), .IntExit(IntExit),
    .IntCause(IntCause), .IntPC(IntPC), .IntMtval(IntMtval),
    .ExcAck(ExcAck), .MretAck(MretAck),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .RedirectAck(RedirectAck),
    .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  // Acknowledge the pending redirect and return to IDLE.
  task automatic ack_redirect();
    RedirectAck = 1'b1;
    step();
    check("ack_rv_low", RedirectValid, 1'b0);
    check("ack_busy_low", Busy, 1'b0);
    RedirectAck = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    ResetN = 1'b0;
    ExtIrq = 0; SoftIrq = 0; TimerIrq = 0;
    ExcValid = 0; ExcCause = 0; ExcPC = 0; ExcMtval = 0;
    MretReq = 0; InstBoundary = 0; CurrPC = 0;
    CsrStatus = 0; CsrIe = 0; CsrTvec = 0; CsrEpc = 0;
    RedirectAck = 0;

    // ---------------- reset values ----------------
    step(); step();
    check("rst_busy", Busy, 1'b0);
    check("rst_rv", RedirectValid, 1'b0);
    check("rst_rpc", RedirectPC, 32'h0);
    check("rst_entry", IntEntry, 1'b0);
    check("rst_cause", IntCause, 32'h0);
    check("rst_ack", {ExcAck, MretAck, IntExit}, 32'h0);
    ResetN = 1'b1;
    step();

    // ---------------- exception entry ----------------
    ExcValid = 1; ExcCause = 4'd2; ExcPC = 32'h100; ExcMtval = 32'hDEAD; CsrTvec = 32'h8000;
    step();
    check("exc_ack", ExcAck, 1'b1);
    check("exc_entry", IntEntry, 1'b1);
    check("exc_cause", IntCause, 32'h00000002);
    check("exc_pc", IntPC, 32'h100);
    check("exc_mtval", IntMtval, 32'hDEAD);
    check("exc_busy", Busy, 1'b1);
    ExcValid = 0;
    step();
    check("exc_entry_1cyc", IntEntry, 1'b0);
    check("exc_ack_1cyc", ExcAck, 1'b0);
    check("exc_rv", RedirectValid, 1'b1);
    check("exc_rpc", RedirectPC, 32'h8000);
    check("exc_cause_hold", IntCause, 32'h00000002);
    for (int i = 0; i < 3; i++) step();
    check("exc_rv_wait", RedirectValid, 1'b1);
    check("exc_rpc_wait", RedirectPC, 32'h8000);
    ack_redirect();

    // ---------------- external beats timer, vectored ----------------
    // MIE held off while the external request passes the synchronizer.
    CsrIe = 32'h880; CsrTvec = 32'h8001; InstBoundary = 1; CurrPC = 32'h4000;
    ExtIrq = 1; TimerIrq = 1;
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      step();
      check("mie0_no_entry", IntEntry, 1'b0);
    end
    CsrStatus = 32'h8;
    step();
    check("mei_entry", IntEntry, 1'b1);
    check("mei_cause", IntCause, 32'h8000000B);
    check("mei_pc", IntPC, 32'h4000);
    check("mei_mtval", IntMtval, 32'h0);
    // Requests dropping after the decision must not cancel the trap.
    ExtIrq = 0; TimerIrq = 0; CsrStatus = 32'h0;
    step();
    check("mei_rv", RedirectValid, 1'b1);
    check("mei_rpc", RedirectPC, 32'h802C);
    check("mei_cause_hold", IntCause, 32'h8000000B);
    ack_redirect();

    // ---------------- MRET, pending timer waits for ack ----------------
    MretReq = 1; CsrEpc = 32'h1235;
    step();
    check("mret_ack", MretAck, 1'b1);
    check("mret_exit", IntExit, 1'b1);
    check("mret_no_entry", IntEntry, 1'b0);
    MretReq = 0;
    CsrStatus = 32'h8; CsrIe = 32'h80; TimerIrq = 1;
    step();
    check("mret_exit_1cyc", IntExit, 1'b0);
    check("mret_rv", RedirectValid, 1'b1);
    check("mret_rpc", RedirectPC, 32'h1234);
    step(); step();
    check("redir_ignores_irq", IntEntry, 1'b0);
    check("redir_hold", RedirectValid, 1'b1);
    RedirectAck = 1;
    step();
    RedirectAck = 0;
    check("ack_cycle_no_entry", IntEntry, 1'b0);
    step();
    check("mti_entry", IntEntry, 1'b1);
    check("mti_cause", IntCause, 32'h80000007);
    TimerIrq = 0; CsrStatus = 32'h0;
    step();
    check("mti_rpc", RedirectPC, 32'h801C);
    ack_redirect();

    // ---------------- exception > MRET > software ----------------
    CsrStatus = 32'h8; CsrIe = 32'h8; SoftIrq = 1;
    ExcValid = 1; ExcCause = 4'd5; ExcPC = 32'h200; ExcMtval = 32'h55; MretReq = 1;
    step();
    check("prio_exc_ack", ExcAck, 1'b1);
    check("prio_no_mret", {MretAck, IntExit}, 32'h0);
    check("prio_cause", IntCause, 32'h00000005);
    ExcValid = 0;
    step();
    check("prio_exc_rpc", RedirectPC, 32'h8000);
    ack_redirect();
    step();
    check("prio_mret_ack", MretAck, 1'b1);
    check("prio_mret_no_entry", IntEntry, 1'b0);
    MretReq = 0; SoftIrq = 0; CsrStatus = 32'h0;
    step();
    check("prio_mret_rpc", RedirectPC, 32'h1234);
    ack_redirect();

    // ---------------- MIE=0 / InstBoundary=0 gating ----------------
    CsrIe = 32'h80; CsrTvec = 32'h8000; TimerIrq = 1; CsrStatus = 32'h0; InstBoundary = 1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      strobes += int'(IntEntry);
    end
    CsrStatus = 32'h8; InstBoundary = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      strobes += int'(IntEntry);
    end
    check("gated_no_entry", strobes, 32'd0);
    check("gated_not_busy", Busy, 1'b0);
    InstBoundary = 1;
    step();
    check("ungated_entry", IntEntry, 1'b1);
    check("ungated_cause", IntCause, 32'h80000007);
    TimerIrq = 0; CsrStatus = 32'h0;
    step();
    check("ungated_rpc", RedirectPC, 32'h8000);
    check("ungated_rv", RedirectValid, 1'b1);

    // ---------------- asynchronous reset in REDIRECT ----------------
    #2 ResetN = 1'b0;
    #1;
    check("arst_rv", RedirectValid, 1'b0);
    check("arst_busy", Busy, 1'b0);
    step();
    ResetN = 1'b1;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      strobes += int'(IntEntry) + int'(IntExit);
    end
    check("arst_no_strobes", strobes, 32'd0);
    check("arst_idle", Busy, 1'b0);

    // ---------------- synchronizer latency ----------------
    CsrStatus = 32'h8; CsrIe = 32'h800; CsrTvec = 32'h8000; CurrPC = 32'h600;
    ExtIrq = 1;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      step();
      check("sync_wait", IntEntry, 1'b0);
    end
    step();
    check("sync_entry", IntEntry, 1'b1);
    check("sync_cause", IntCause, 32'h8000000B);
    check("sync_pc", IntPC, 32'h600);
    ExtIrq = 0; CsrStatus = 32'h0;
    step();
    check("sync_rpc", RedirectPC, 32'h8000);
    ack_redirect();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/interrupt controller that sits directly upstream of the CSR file.
- Arbitrates synchronous exceptions, machine interrupts (external, software, timer) and MRET.
- Drives the CSR file's IntEntry/IntExit/IntCause/IntPC/IntMtval inputs.
- Consumes the CSR file's CsrStatus/CsrIe/CsrTvec/CsrEpc outputs and issues a PC redirect to the fetch stage with a valid/ack handshake.

Parameters:
SYNC_STAGES, 2, flop depth of synchronizer on each asynchronous interrupt input (legal 2..4)
VECTORED_EN, 1, 1 = honour mtvec mode 01 (vectored); 0 = always direct

Ports:
Clk  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
ExtIrq  in  1  machine external interrupt, level, asynchronous
SoftIrq  in  1  machine software interrupt, level, synchronous
TimerIrq  in  1  machine timer interrupt, level, synchronous
ExcValid  in  1  synchronous exception request, held until accepted
ExcCause  in  4  exception code (mcause[30:0] low bits)
ExcPC  in  32  PC of faulting instruction
ExcMtval  in  32  trap value for exception
MretReq  in  1  MRET retired, held until accepted
InstBoundary  in  1  pipeline at an instruction boundary; interrupts only taken when 1
CurrPC  in  32  PC of next instruction to execute (saved as mepc for interrupts)
CsrStatus  in  32  mstatus from CSR file (bit 3 = MIE)
CsrIe  in  32  mie from CSR file (bits 11/7/3)
CsrTvec  in  32  mtvec from CSR file
CsrEpc  in  32  mepc from CSR file
IntEntry  out  1  one-cycle pulse: CSR file latches cause/pc/mtval, clears MIE
IntExit  out  1  one-cycle pulse: CSR file restores MIE
IntCause  out  32  mcause value, valid while IntEntry=1
IntPC  out  32  mepc value, valid while IntEntry=1
IntMtval  out  32  mtval value, valid while IntEntry=1
ExcAck  out  1  one-cycle pulse, exception accepted
MretAck  out  1  one-cycle pulse, MRET accepted
RedirectValid  out  1  new PC available to fetch
RedirectPC  out  32  target PC
RedirectAck  in  1  fetch has taken RedirectPC
Busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, ResetN=0): state IDLE; all outputs 0; synchronizer flops 0. Deassertion takes effect on the next Clk edge.
- ExtIrq passes through a SYNC_STAGES flop chain; the irq latency to decision is SYNC_STAGES cycles.
- Pending: MEIP=extSync&CsrIe[11], MSIP=SoftIrq&CsrIe[3], MTIP=TimerIrq&CsrIe[7]. Interrupt eligible = CsrStatus[3] & InstBoundary & any pending.
- Priority in IDLE (highest first): ExcValid > MretReq > MEI > MSI > MTI.
- States: IDLE, ENTRY, EXIT, REDIRECT.
- IDLE + ExcValid -> ENTRY. Registers IntCause={1'b0,27'b0,ExcCause}, IntPC=ExcPC, IntMtval=ExcMtval. ExcAck=1 in the same cycle.
- IDLE + MretReq (no ExcValid) -> EXIT. MretAck=1 the same cycle.
- IDLE + eligible interrupt -> ENTRY. Registers IntCause={1'b1,27'b0,code} (code 11/3/7), IntPC=CurrPC, IntMtval=0.
- ENTRY: IntEntry=1 for exactly one cycle. RedirectPC computed in this cycle and registered:
  - Vectored: CsrTvec[1:0]==01 & VECTORED_EN & interrupt -> {CsrTvec[31:2],2'b00} + 4*code (32-bit wrap).
  - Otherwise: {CsrTvec[31:2],2'b00}.
  - Next state REDIRECT.
- EXIT: IntExit=1 for exactly one cycle. RedirectPC={CsrEpc[31:1],1'b0}. Next state REDIRECT.
- REDIRECT: RedirectValid=1, RedirectPC stable; all requests ignored. RedirectAck=1 -> IDLE (RedirectValid drops the next cycle). A waiting RedirectAck is unbounded.
- RedirectAck outside REDIRECT is ignored.
- Interrupts deasserting after the IDLE decision do not cancel the trap. Cause stays as latched.
- IntCause/IntPC/IntMtval hold their last value outside ENTRY.
- No trap entry is possible in the cycle after an exit; the MIE restore is observed via CsrStatus only after REDIRECT.
- Reset mid-operation: immediate return to IDLE, pulses and RedirectValid forced to 0, the in-flight trap is dropped.

Test Plan:
- Reset → Busy=0, all outputs 0. ExcValid=1, ExcCause=2, ExcPC=0x100, ExcMtval=0xDEAD, CsrTvec=0x8000 → ExcAck next edge. IntEntry pulse with IntCause=0x00000002, IntPC=0x100, IntMtval=0xDEAD. RedirectPC=0x8000 held until RedirectAck.
- CsrStatus[3]=1, CsrIe=0x880, TimerIrq=1, ExtIrq=1, CsrTvec=0x8001, InstBoundary=1 → after sync latency IntCause=0x8000000B, RedirectPC=0x802C, IntMtval=0.
- MretReq=1, CsrEpc=0x1235 → MretAck, IntExit one cycle, RedirectPC=0x1234. The interrupt pending during REDIRECT is taken only after RedirectAck.
- ExcValid and MretReq and SoftIrq all asserted in IDLE → exception taken first (ExcAck only); MRET then accepted after the redirect completes.
- CsrStatus[3]=0 or InstBoundary=0 with TimerIrq=1 → no IntEntry for 20 cycles. Setting MIE → entry with cause 0x80000007.
- ResetN=0 while in REDIRECT → RedirectValid=0 immediately (asynchronous). After release, Busy=0 and no IntEntry/IntExit is emitted.
